// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle shared by the UART register controller, the TX FIFO and the UART core.
// With UART_TX_FIFO_IRQ_EN defined it also carries the THR-empty interrupt enable and request.
interface uart_tx_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          flush;
  logic          clr_overflow;
  logic          tx_busy;
  logic          ena_tx;
  logic [7:0]    tx_data;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          thre;
  logic          temt;
`ifdef UART_TX_FIFO_IRQ_EN
  logic          irq_en;
  logic          tx_irq;

  modport master (
    output wr_en, wr_data, flush, clr_overflow, tx_busy, irq_en,
    input  ena_tx, tx_data, count, full, empty, overflow, thre, temt, tx_irq
  );
  modport slave (
    input  wr_en, wr_data, flush, clr_overflow, tx_busy, irq_en,
    output ena_tx, tx_data, count, full, empty, overflow, thre, temt, tx_irq
  );
`else
  modport master (
    output wr_en, wr_data, flush, clr_overflow, tx_busy,
    input  ena_tx, tx_data, count, full, empty, overflow, thre, temt
  );
  modport slave (
    input  wr_en, wr_data, flush, clr_overflow, tx_busy,
    output ena_tx, tx_data, count, full, empty, overflow, thre, temt
  );
`endif
endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO feeding the UART core one byte per ena_tx pulse, paced by tx_busy.
// Optional THR-empty interrupt enabled by defining UART_TX_FIFO_IRQ_EN.
module uart_tx_fifo #(
  parameter int DEPTH        = 16,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_fifo_if.slave bus
);
  localparam int             AW         = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [7:0]     TMO_LAST   = 8'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_RISE, WAIT_FALL} state_t;

  state_t          r_state;
  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            r_overflow;
  logic            r_ena_tx;
  logic [7:0]      r_tx_data;
  logic [7:0]      r_tmo;

  logic            w_full;
  logic            w_empty;
  logic            w_launch;
  logic            w_push;
  logic            w_drop;

  assign w_full   = (r_count == FULL_COUNT);
  assign w_empty  = (r_count == '0);
  assign w_launch = (r_state == IDLE) && !w_empty && !bus.tx_busy && !bus.flush;
  // A pop on the same edge frees a slot, so a full FIFO still accepts the write.
  assign w_push   = bus.wr_en && !bus.flush && (!w_full || w_launch);
  assign w_drop   = bus.wr_en && !bus.flush && w_full && !w_launch;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (bus.flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
        if (w_launch) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        if (w_push && !w_launch) begin
          r_count <= r_count + (AW+1)'(1);
        end else if (!w_push && w_launch) begin
          r_count <= r_count - (AW+1)'(1);
        end
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (bus.clr_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // A core that never raises tx_busy is released after BUSY_TIMEOUT cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_ena_tx  <= 1'b0;
      r_tx_data <= 8'h00;
      r_tmo     <= 8'h00;
    end else begin
      r_ena_tx <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_launch) begin
            r_tx_data <= r_mem[r_rd_ptr];
            r_ena_tx  <= 1'b1;
            r_tmo     <= 8'h00;
            r_state   <= WAIT_RISE;
          end
        end
        WAIT_RISE: begin
          if (bus.tx_busy) begin
            r_state <= WAIT_FALL;
          end else begin
            r_tmo <= r_tmo + 8'd1;
            if (r_tmo == TMO_LAST) begin
              r_state <= IDLE;
            end
          end
        end
        WAIT_FALL: begin
          if (!bus.tx_busy) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef UART_TX_FIFO_IRQ_EN
  logic r_tx_irq;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_irq <= 1'b0;
    end else begin
      r_tx_irq <= bus.irq_en && w_empty && (r_state == IDLE);
    end
  end

  assign bus.tx_irq = r_tx_irq;
`endif

  assign bus.ena_tx   = r_ena_tx;
  assign bus.tx_data  = r_tx_data;
  assign bus.count    = r_count;
  assign bus.full     = w_full;
  assign bus.empty    = w_empty;
  assign bus.overflow = r_overflow;
  assign bus.thre     = w_empty;
  assign bus.temt     = w_empty && (r_state == IDLE) && !bus.tx_busy;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed vector table, corner-case sequences and
// randomized traffic compared against a queue-based reference model of the FIFO and launch rules.
module tb_uart_tx_fifo;
  localparam int DEPTH        = 16;
  localparam int BUSY_TIMEOUT = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(
    .DEPTH        (DEPTH),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit         we;
    logic [7:0] d;
    bit         fl;
    bit         clr;
    bit         busy;
    bit         ena;
    logic [7:0] txd;
    int         cnt;
    bit         emp;
    bit         ful;
    bit         ovf;
    bit         temt;
  } vec_t;

  vec_t vecs[13];

  int nChecks = 0;
  int nFails  = 0;
  int cycleNo = 0;

  // Reference model state
  logic [7:0] modelQ[$];
  logic [7:0] launchLog[$];
  int         launchCycles[$];
  bit         inflight;
  bit         sawBusy;
  int         waitCnt;
  logic [7:0] lastData;
  bit         modelOvf;

  // Last applied stimulus
  bit         aWe, aFl, aClr, aBusy;
  logic [7:0] aD;

  // Behavioural UART core
  bit autoCore, forceBusy, randCore;
  int pendRise = -1;
  int pendLen  = 0;
  int holdLeft = 0;
  int coreDelay = 2;
  int coreLen   = 10;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycleNo);
    end
  endtask

  task automatic modelReset();
    modelQ.delete();
    launchLog.delete();
    launchCycles.delete();
    inflight = 0;
    sawBusy  = 0;
    waitCnt  = 0;
    lastData = 8'h00;
    modelOvf = 0;
    pendRise = -1;
    holdLeft = 0;
  endtask

  task automatic applyStimulus(input bit we, input logic [7:0] d, input bit fl, input bit clr, input bit busy);
    bus.wr_en        = we;
    bus.wr_data      = d;
    bus.flush        = fl;
    bus.clr_overflow = clr;
    bus.tx_busy      = busy;
    aWe = we; aD = d; aFl = fl; aClr = clr; aBusy = busy;
    @(posedge clk);
    #1;
    cycleNo++;
  endtask

  // Advances the model across the edge just taken and compares every output.
  task automatic checkOutput();
    bit expLaunch;
    bit drop;
    bit expIrq;
    expIrq    = (modelQ.size() == 0) && !inflight;
    expLaunch = 0;
    if (!inflight) begin
      expLaunch = (modelQ.size() != 0) && !aBusy && !aFl;
    end else if (!sawBusy) begin
      if (aBusy) begin
        sawBusy = 1;
      end else begin
        waitCnt++;
        if (waitCnt == BUSY_TIMEOUT) inflight = 0;
      end
    end else if (!aBusy) begin
      inflight = 0;
    end
    check("ena_tx", bus.ena_tx, expLaunch);
    if (expLaunch) begin
      lastData = modelQ.pop_front();
      inflight = 1;
      sawBusy  = 0;
      waitCnt  = 0;
      launchLog.push_back(lastData);
    end
    drop = 0;
    if (aFl) begin
      modelQ.delete();
    end else if (aWe) begin
      if (modelQ.size() < DEPTH) modelQ.push_back(aD);
      else drop = 1;
    end
    if (drop) modelOvf = 1;
    else if (aClr) modelOvf = 0;
    check("tx_data", bus.tx_data, lastData);
    check("count", bus.count, modelQ.size());
    check("empty", bus.empty, modelQ.size() == 0);
    check("full", bus.full, modelQ.size() == DEPTH);
    check("thre", bus.thre, modelQ.size() == 0);
    check("overflow", bus.overflow, modelOvf);
    check("temt", bus.temt, (modelQ.size() == 0) && !inflight && !aBusy);
`ifdef UART_TX_FIFO_IRQ_EN
    check("tx_irq", bus.tx_irq, expIrq);
`endif
    if (bus.ena_tx === 1'b1) begin
      launchCycles.push_back(cycleNo);
      if (autoCore) begin
        pendRise = randCore ? $urandom_range(0, 6) : coreDelay;
        pendLen  = randCore ? $urandom_range(1, 5) : coreLen;
      end
    end
  endtask

  task automatic tick(input bit we, input logic [7:0] d, input bit fl, input bit clr);
    bit b;
    if (pendRise == 0) begin
      holdLeft = pendLen;
      pendRise = -1;
    end else if (pendRise > 0) begin
      pendRise--;
    end
    b = forceBusy || (holdLeft > 0);
    if (holdLeft > 0) holdLeft--;
    applyStimulus(we, d, fl, clr, b);
    checkOutput();
  endtask

  task automatic checkResetState(input string tag);
    check({tag, "_ena_tx"}, bus.ena_tx, 0);
    check({tag, "_tx_data"}, bus.tx_data, 0);
    check({tag, "_count"}, bus.count, 0);
    check({tag, "_empty"}, bus.empty, 1);
    check({tag, "_full"}, bus.full, 0);
    check({tag, "_thre"}, bus.thre, 1);
    check({tag, "_overflow"}, bus.overflow, 0);
    check({tag, "_temt"}, bus.temt, 1);
`ifdef UART_TX_FIFO_IRQ_EN
    check({tag, "_tx_irq"}, bus.tx_irq, 0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{0, 8'h00, 0, 0, 0,  0, 8'h00, 0, 1, 0, 0, 1};
    vecs[1]  = '{1, 8'h55, 0, 0, 0,  0, 8'h00, 1, 0, 0, 0, 0};
    vecs[2]  = '{0, 8'h00, 0, 0, 0,  1, 8'h55, 0, 1, 0, 0, 0};
    vecs[3]  = '{0, 8'h00, 0, 0, 1,  0, 8'h55, 0, 1, 0, 0, 0};
    vecs[4]  = '{0, 8'h00, 0, 0, 1,  0, 8'h55, 0, 1, 0, 0, 0};
    vecs[5]  = '{0, 8'h00, 0, 0, 0,  0, 8'h55, 0, 1, 0, 0, 1};
    vecs[6]  = '{1, 8'hA3, 0, 0, 1,  0, 8'h55, 1, 0, 0, 0, 0};
    vecs[7]  = '{0, 8'h00, 0, 0, 1,  0, 8'h55, 1, 0, 0, 0, 0};
    vecs[8]  = '{0, 8'h00, 0, 0, 0,  1, 8'hA3, 0, 1, 0, 0, 0};
    vecs[9]  = '{1, 8'h77, 1, 0, 0,  0, 8'hA3, 0, 1, 0, 0, 0};
    vecs[10] = '{0, 8'h00, 0, 0, 0,  0, 8'hA3, 0, 1, 0, 0, 0};
    vecs[11] = '{0, 8'h00, 0, 0, 0,  0, 8'hA3, 0, 1, 0, 0, 0};
    vecs[12] = '{0, 8'h00, 0, 0, 0,  0, 8'hA3, 0, 1, 0, 0, 1};

    reset            = 1'b0;
    bus.wr_en        = 1'b0;
    bus.wr_data      = 8'h00;
    bus.flush        = 1'b0;
    bus.clr_overflow = 1'b0;
    bus.tx_busy      = 1'b0;
`ifdef UART_TX_FIFO_IRQ_EN
    bus.irq_en       = 1'b1;
`endif
    autoCore  = 0;
    forceBusy = 0;
    randCore  = 0;
    modelReset();

    #12;
    checkResetState("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].we, vecs[i].d, vecs[i].fl, vecs[i].clr, vecs[i].busy);
      checkOutput();
      check($sformatf("vec%0d_ena_tx", i), bus.ena_tx, vecs[i].ena);
      check($sformatf("vec%0d_tx_data", i), bus.tx_data, vecs[i].txd);
      check($sformatf("vec%0d_count", i), bus.count, vecs[i].cnt);
      check($sformatf("vec%0d_empty", i), bus.empty, vecs[i].emp);
      check($sformatf("vec%0d_full", i), bus.full, vecs[i].ful);
      check($sformatf("vec%0d_overflow", i), bus.overflow, vecs[i].ovf);
      check($sformatf("vec%0d_temt", i), bus.temt, vecs[i].temt);
    end

    $display("[TB] back-to-back bytes with paced core");
    launchLog.delete();
    autoCore = 1; coreDelay = 2; coreLen = 10;
    tick(1, 8'h01, 0, 0);
    tick(1, 8'h02, 0, 0);
    tick(1, 8'h03, 0, 0);
    for (int k = 0; k < 400 && (launchLog.size() < 3 || bus.temt !== 1'b1); k++) tick(0, 8'h00, 0, 0);
    check("b2b_launches", launchLog.size(), 3);
    for (int i = 0; i < 3 && i < launchLog.size(); i++) check($sformatf("b2b_byte%0d", i), launchLog[i], i + 1);

    $display("[TB] overflow with core held busy");
    launchLog.delete();
    forceBusy = 1;
    for (int i = 0; i < 17; i++) tick(1, 8'(8'h10 + i), 0, 0);
    check("ovf_full", bus.full, 1);
    check("ovf_count", bus.count, 16);
    check("ovf_flag", bus.overflow, 1);
    forceBusy = 0; coreDelay = 1; coreLen = 2;
    for (int k = 0; k < 1000 && (launchLog.size() < 16 || bus.temt !== 1'b1); k++) tick(0, 8'h00, 0, 0);
    check("ovf_drained", launchLog.size(), 16);
    for (int i = 0; i < 16 && i < launchLog.size(); i++) check($sformatf("ovf_byte%0d", i), launchLog[i], 8'h10 + i);
    tick(0, 8'h00, 0, 1);
    check("ovf_cleared", bus.overflow, 0);

    $display("[TB] push on the pop edge of a full FIFO");
    launchLog.delete();
    forceBusy = 1;
    for (int i = 0; i < 16; i++) tick(1, 8'(8'h20 + i), 0, 0);
    check("pp_full_before", bus.full, 1);
    forceBusy = 0; coreDelay = 1; coreLen = 1;
    tick(1, 8'hEE, 0, 0);
    check("pp_ena_tx", bus.ena_tx, 1);
    check("pp_count", bus.count, 16);
    check("pp_overflow", bus.overflow, 0);
    for (int k = 0; k < 1000 && (launchLog.size() < 17 || bus.temt !== 1'b1); k++) tick(0, 8'h00, 0, 0);
    check("pp_drained", launchLog.size(), 17);
    if (launchLog.size() == 17) check("pp_last_byte", launchLog[16], 8'hEE);

    $display("[TB] busy timeout and flush");
    launchCycles.delete();
    autoCore = 0;
    tick(1, 8'hA0, 0, 0);
    tick(1, 8'hA1, 0, 0);
    for (int k = 0; k < 50 && launchCycles.size() < 2; k++) tick(0, 8'h00, 0, 0);
    check("tmo_launches", launchCycles.size(), 2);
    if (launchCycles.size() >= 2) check("tmo_gap", launchCycles[1] - launchCycles[0], BUSY_TIMEOUT + 1);
    for (int k = 0; k < 50 && bus.temt !== 1'b1; k++) tick(0, 8'h00, 0, 0);
    launchLog.delete();
    autoCore = 1; coreDelay = 1; coreLen = 6;
    for (int i = 0; i < 6; i++) tick(1, 8'(8'hB0 + i), 0, 0);
    check("fl_count_before", bus.count, 5);
    tick(0, 8'h00, 1, 0);
    check("fl_count", bus.count, 0);
    check("fl_empty", bus.empty, 1);
    for (int k = 0; k < 100 && bus.temt !== 1'b1; k++) tick(0, 8'h00, 0, 0);
    check("fl_temt", bus.temt, 1);
    check("fl_launches", launchLog.size(), 1);

    $display("[TB] reset while waiting for tx_busy to fall");
    launchLog.delete();
    coreDelay = 0; coreLen = 20;
    for (int i = 0; i < 4; i++) tick(1, 8'(8'hC0 + i), 0, 0);
    tick(0, 8'h00, 0, 0);
    check("rst_count_before", bus.count, 3);
    check("rst_busy_before", bus.temt, 0);
    #2;
    bus.tx_busy = 1'b0;
    reset = 1'b0;
    #1;
    checkResetState("midrst");
    modelReset();
    autoCore = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 10; k++) tick(0, 8'h00, 0, 0);
    check("rst_no_launch", launchLog.size(), 0);

    $display("[TB] randomized traffic");
    launchLog.delete();
    autoCore = 1; randCore = 1;
    for (int k = 0; k < 1500; k++) begin
      tick($urandom_range(0, 99) < 45, 8'($urandom), $urandom_range(0, 199) == 0, $urandom_range(0, 49) == 0);
    end
    for (int k = 0; k < 2000 && (modelQ.size() != 0 || bus.temt !== 1'b1); k++) tick(0, 8'h00, 0, 0);
    check("rand_drained", bus.temt, 1);
    check("rand_launched", launchLog.size() > 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Transmit-side buffer between the bus-facing UART register controller and the synchronous RS-232 UART core. It accepts bytes written to THR, stores them in a circular FIFO and launches them one at a time into the core. Each launch is a one-cycle ena_tx pulse with tx_data. The core's tx_busy handshake paces the launches. It also supplies the THRE/TEMT status bits for LSR.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2; AW = log2(DEPTH) derived locally.
BUSY_TIMEOUT, 4, cycles to wait for tx_busy to rise after a launch before treating the byte as sent; 1..255.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
wr_en  input  1  push wr_data (one byte per cycle)
wr_data  input  8  byte to transmit
flush  input  1  discard all queued bytes (FCR TX reset)
clr_overflow  input  1  clear sticky overflow flag
tx_busy  input  1  UART core transmitter busy
ena_tx  output  1  one-cycle launch strobe to core
tx_data  output  8  byte to core, stable from launch until next launch
count  output  AW+1  number of queued bytes, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
overflow  output  1  sticky: a write was dropped
thre  output  1  LSR THRE = empty
temt  output  1  LSR TEMT = empty & state==IDLE & ~tx_busy

Behaviour:
- Reset (reset==0, asynchronous): pointers=0, count=0, state=IDLE, ena_tx=0, tx_data=0, overflow=0, timeout counter=0. Outputs: empty=1, full=0, thre=1, temt=1 (tx_busy low). Reset mid-transfer abandons the byte. The core is not signalled.
- Storage: mem[DEPTH]x8, wr_ptr/rd_ptr are AW bits and wrap modulo DEPTH. count is a separate register. mem itself is not reset.
- Push: on wr_en, when (!full or pop this cycle) and !flush: mem[wr_ptr]<=wr_data, wr_ptr++.
- Push while full with no pop: byte dropped, pointers unchanged, overflow<=1.
- Pop occurs only in the FSM launch edge.
- Count update: push&pop keeps count unchanged; push only adds 1; pop only subtracts 1.
- Full with simultaneous push+pop: both are accepted, count stays DEPTH.
- flush: wr_ptr=rd_ptr=0, count=0. Flush beats push (pushed byte dropped, no overflow) and beats pop.
- flush does not abort a byte already launched; the FSM continues its current wait states.
- overflow: set has priority over clr_overflow in the same cycle.
- FSM states: IDLE, WAIT_RISE, WAIT_FALL. ena_tx defaults to 0 every cycle.
  - IDLE: if count!=0 & ~tx_busy & ~flush: tx_data<=mem[rd_ptr], ena_tx<=1, pop (rd_ptr++), tmo<=0, go to WAIT_RISE.
  - WAIT_RISE: if tx_busy go to WAIT_FALL. Otherwise tmo++, and when tmo==BUSY_TIMEOUT-1 go to IDLE.
  - WAIT_FALL: when ~tx_busy go to IDLE.
- Latency: a byte pushed at edge E into an empty FIFO with IDLE state and idle core produces ena_tx=1 for the cycle after edge E+1.
- Back-to-back bytes: the next launch comes at the first IDLE edge after tx_busy falls. Minimum gap is 1 cycle of tx_busy low.
- IDLE with tx_busy already high (core busy from an external source) waits in IDLE; no launch.
- Exactly one ena_tx pulse per popped byte. No byte is launched twice.

Optional Feature:
UART_TX_FIFO_IRQ_EN:
- When defined: adds input irq_en (1) and output tx_irq (1).
- tx_irq is registered and equals irq_en & empty & (state==IDLE).
- It is the THR-empty interrupt. It clears the cycle after a push makes the FIFO non-empty.
- It is low at reset.
- When undefined: neither port exists and no interrupt logic is synthesised.

Test Plan:
- Reset, idle core, push 0x55 at edge E -> ena_tx=1 for exactly one cycle after E+1 with tx_data=0x55. count returns to 0, thre=1. temt=0 until tx_busy falls.
- Push 0x01..0x03 back to back. Bench models tx_busy high 2 cycles after ena_tx for 10 cycles -> three ena_tx pulses carrying 0x01,0x02,0x03 in order, none issued while tx_busy=1.
- Hold tx_busy=1, push 17 bytes (DEPTH=16) -> full=1, count=16, overflow=1, 17th byte lost. Release tx_busy -> 16 bytes drain in order. clr_overflow -> overflow=0.
- Full FIFO, push during the pop edge -> push accepted, count stays 16, no overflow.
- Core never raises tx_busy -> FSM returns to IDLE after BUSY_TIMEOUT (4) cycles and launches the next byte. flush with 5 queued bytes -> count=0, empty=1, in-flight byte still completes.
- Assert reset low in WAIT_FALL with 3 bytes queued -> immediately ena_tx=0, count=0, empty=1, state IDLE. No ena_tx pulse after reset release until a new push.
